// File: rtl/sample_decimator_if.sv
// Sample stream between source mux, decimator and packer: control, input strobe/sample, output strobe/mean.
// No backpressure on either side; io_out_valid is a one-cycle pulse.
interface sample_decimator_if #(
    parameter int WIDTH = 12
);
    logic             io_enable;
    logic [3:0]       io_log2_ratio;
    logic             io_in_valid;
    logic [WIDTH-1:0] io_in_bits;
    logic             io_out_valid;
    logic [WIDTH-1:0] io_out_bits;

    modport master (
        output io_enable,
        output io_log2_ratio,
        output io_in_valid,
        output io_in_bits,
        input  io_out_valid,
        input  io_out_bits
    );

    modport slave (
        input  io_enable,
        input  io_log2_ratio,
        input  io_in_valid,
        input  io_in_bits,
        output io_out_valid,
        output io_out_bits
    );
endinterface

// File: rtl/sample_decimator.sv
// Boxcar decimator: mean of 2^k samples, 1-cycle latency after the final sample, no backpressure.
// DECIM_ROUND_EN selects round-half-up; the default build truncates.
module sample_decimator #(
    parameter int WIDTH    = 12,
    parameter int MAX_LOG2 = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    sample_decimator_if.slave    bus
);
    localparam int         ACC_W = WIDTH + MAX_LOG2;
    localparam logic [3:0] K_MAX = 4'(MAX_LOG2);

    logic [ACC_W-1:0]    r_acc;
    logic [MAX_LOG2-1:0] r_cnt;
    logic [3:0]          r_k_act;
    logic                r_out_vld;
    logic [WIDTH-1:0]    r_out_bits;

    logic                w_accept;
    logic [3:0]          w_k_clamp;
    logic [3:0]          w_k_eff;
    logic [MAX_LOG2:0]   w_last_cnt;
    logic                w_last;
    logic [ACC_W-1:0]    w_sum;
    logic [ACC_W-1:0]    w_sum_q;
    logic [WIDTH-1:0]    w_mean;

    assign w_accept  = bus.io_in_valid & bus.io_enable;
    assign w_k_clamp = (bus.io_log2_ratio > K_MAX) ? K_MAX : bus.io_log2_ratio;

    // The first sample of a block already uses the ratio it latches.
    assign w_k_eff    = (r_cnt == '0) ? w_k_clamp : r_k_act;
    assign w_last_cnt = ((MAX_LOG2+1)'(1) << w_k_eff) - (MAX_LOG2+1)'(1);
    assign w_last     = ({1'b0, r_cnt} == w_last_cnt);

    assign w_sum = r_acc + ACC_W'(bus.io_in_bits);

`ifdef DECIM_ROUND_EN
    logic [ACC_W-1:0] w_half;
    assign w_half  = (w_k_eff == 4'd0) ? '0 : (ACC_W'(1) << (w_k_eff - 4'd1));
    assign w_sum_q = w_sum + w_half;
`else
    assign w_sum_q = w_sum;
`endif

    assign w_mean = WIDTH'(w_sum_q >> w_k_eff);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_k_act    <= '0;
            r_out_vld  <= 1'b0;
            r_out_bits <= '0;
        end else if (!bus.io_enable) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_out_vld <= 1'b0;
        end else begin
            r_out_vld <= w_accept & w_last;
            if (w_accept) begin
                if (r_cnt == '0) begin
                    r_k_act <= w_k_clamp;
                end
                if (w_last) begin
                    r_out_bits <= w_mean;
                    r_acc      <= '0;
                    r_cnt      <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + MAX_LOG2'(1);
                end
            end
        end
    end

    assign bus.io_out_valid = r_out_vld;
    assign bus.io_out_bits  = r_out_bits;
endmodule

// File: tb/tb_sample_decimator.sv
// Directed bench for sample_decimator: vector table plus long-block, abort and reset sequences.
module tb_sample_decimator;
    logic clock;
    logic reset;
    int   n_cmp;
    int   n_err;

    sample_decimator_if #(.WIDTH(12)) bus();

    sample_decimator #(.WIDTH(12), .MAX_LOG2(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        en;
        logic [3:0]  k;
        logic        vld;
        logic [11:0] din;
        logic        exp_vld;
        logic [11:0] exp_bits;
    } vec_t;

    vec_t vecs[$];

`ifdef DECIM_ROUND_EN
    localparam logic [11:0] MEAN_1234 = 12'h003;
`else
    localparam logic [11:0] MEAN_1234 = 12'h002;
`endif

    function automatic vec_t mk(logic en, logic [3:0] k, logic vld, logic [11:0] din,
                                logic exp_vld, logic [11:0] exp_bits);
        vec_t v;
        v.en = en; v.k = k; v.vld = vld; v.din = din;
        v.exp_vld = exp_vld; v.exp_bits = exp_bits;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic en, input logic [3:0] k, input logic vld, input logic [11:0] din);
        bus.io_enable     = en;
        bus.io_log2_ratio = k;
        bus.io_in_valid   = vld;
        bus.io_in_bits    = din;
    endtask

    // Feeds n equal samples back to back; only the last may pulse, with mean exp_bits.
    task automatic run_block(input string name, input logic [3:0] k, input int n,
                             input logic [11:0] din, input logic [11:0] exp_bits);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, k, 1'b1, din);
            tick();
            chk({name, "_vld"}, 32'(bus.io_out_valid), 32'(i == n - 1));
        end
        chk({name, "_bits"}, 32'(bus.io_out_bits), 32'(exp_bits));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        drive(1'b0, 4'd0, 1'b0, 12'h000);
        repeat (2) tick();
        reset = 1'b0;
        chk("reset_vld", 32'(bus.io_out_valid), 32'd0);
        chk("reset_bits", 32'(bus.io_out_bits), 32'd0);

        // bypass
        vecs.push_back(mk(1, 0, 1, 12'h123, 1, 12'h123));
        vecs.push_back(mk(1, 0, 1, 12'hABC, 1, 12'hABC));
        vecs.push_back(mk(1, 0, 0, 12'h000, 0, 12'hABC));
        // k=2: 1,2,3,4 with a gap stalling the count
        vecs.push_back(mk(1, 2, 1, 12'd1, 0, 12'hABC));
        vecs.push_back(mk(1, 2, 1, 12'd2, 0, 12'hABC));
        vecs.push_back(mk(1, 2, 0, 12'd0, 0, 12'hABC));
        vecs.push_back(mk(1, 2, 1, 12'd3, 0, 12'hABC));
        vecs.push_back(mk(1, 2, 1, 12'd4, 1, MEAN_1234));
        vecs.push_back(mk(1, 2, 0, 12'd0, 0, MEAN_1234));
        // aborted partial block, then a full block of 8s
        vecs.push_back(mk(1, 2, 1, 12'hFFF, 0, MEAN_1234));
        vecs.push_back(mk(1, 2, 1, 12'hFFF, 0, MEAN_1234));
        vecs.push_back(mk(1, 2, 1, 12'hFFF, 0, MEAN_1234));
        vecs.push_back(mk(0, 2, 1, 12'hFFF, 0, MEAN_1234));
        vecs.push_back(mk(1, 2, 1, 12'd8, 0, MEAN_1234));
        vecs.push_back(mk(1, 2, 1, 12'd8, 0, MEAN_1234));
        vecs.push_back(mk(1, 2, 1, 12'd8, 0, MEAN_1234));
        vecs.push_back(mk(1, 2, 1, 12'd8, 1, 12'h008));
        // ratio change mid-block only takes effect at the next block
        vecs.push_back(mk(1, 2, 1, 12'd4, 0, 12'h008));
        vecs.push_back(mk(1, 2, 1, 12'd4, 0, 12'h008));
        vecs.push_back(mk(1, 1, 1, 12'd8, 0, 12'h008));
        vecs.push_back(mk(1, 1, 1, 12'd8, 1, 12'h006));
        vecs.push_back(mk(1, 1, 1, 12'd6, 0, 12'h006));
        vecs.push_back(mk(1, 1, 1, 12'd2, 1, 12'h004));
        // final sample accepted, enable drops while the pulse is out
        vecs.push_back(mk(1, 1, 1, 12'd5, 0, 12'h004));
        vecs.push_back(mk(1, 1, 1, 12'd7, 1, 12'h006));
        vecs.push_back(mk(0, 1, 0, 12'd0, 0, 12'h006));
        // final sample arrives with enable low: not accepted, block flushed
        vecs.push_back(mk(1, 1, 1, 12'd3, 0, 12'h006));
        vecs.push_back(mk(0, 1, 1, 12'd9, 0, 12'h006));
        vecs.push_back(mk(1, 1, 1, 12'd1, 0, 12'h006));
        vecs.push_back(mk(1, 1, 1, 12'd1, 1, 12'h001));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].en, vecs[i].k, vecs[i].vld, vecs[i].din);
            tick();
            chk($sformatf("vec%0d_vld", i), 32'(bus.io_out_valid), 32'(vecs[i].exp_vld));
            chk($sformatf("vec%0d_bits", i), 32'(bus.io_out_bits), 32'(vecs[i].exp_bits));
        end

        // k=8 full-scale block then zero block, back to back
        run_block("k8_max", 4'd8, 256, 12'hFFF, 12'hFFF);
        run_block("k8_zero", 4'd8, 256, 12'h000, 12'h000);

        // clamp and mid-block reset
        drive(1'b1, 4'd0, 1'b1, 12'h5A5);
        tick();
        chk("pre_rst_bits", 32'(bus.io_out_bits), 32'h5A5);
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 4'd15, 1'b1, 12'h010);
            tick();
            chk("k15_partial_vld", 32'(bus.io_out_valid), 32'd0);
        end
        reset = 1'b1;
        drive(1'b1, 4'd15, 1'b0, 12'h000);
        tick();
        reset = 1'b0;
        chk("mid_rst_vld", 32'(bus.io_out_valid), 32'd0);
        chk("mid_rst_bits", 32'(bus.io_out_bits), 32'd0);
        run_block("k15_full", 4'd15, 256, 12'h020, 12'h020);
        drive(1'b1, 4'd15, 1'b0, 12'h000);
        tick();
        chk("k15_after_vld", 32'(bus.io_out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
